// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - PS/2 scancodes, receive FSM encoding, event layout and calculator key map.
package ps2_pkg;

  localparam logic [7:0] SC_0     = 8'h45;
  localparam logic [7:0] SC_1     = 8'h16;
  localparam logic [7:0] SC_2     = 8'h1E;
  localparam logic [7:0] SC_3     = 8'h26;
  localparam logic [7:0] SC_4     = 8'h25;
  localparam logic [7:0] SC_5     = 8'h2E;
  localparam logic [7:0] SC_6     = 8'h36;
  localparam logic [7:0] SC_7     = 8'h3D;
  localparam logic [7:0] SC_8     = 8'h3E;
  localparam logic [7:0] SC_9     = 8'h46;
  localparam logic [7:0] SC_PLUS  = 8'h79;
  localparam logic [7:0] SC_MINUS = 8'h7B;
  localparam logic [7:0] SC_MUL   = 8'h7C;
  localparam logic [7:0] SC_DIV   = 8'h4A;
  localparam logic [7:0] SC_ENT   = 8'h5A;
  localparam logic [7:0] SC_BS    = 8'h66;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;

  localparam int EVT_W = 14;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [3:0] key;
  } evt_t;

  function automatic logic [3:0] key_map(input logic [7:0] code, input logic ext);
    logic [3:0] k;
    k = 4'hF;
    if (ext) begin
      case (code)
        SC_DIV:  k = 4'hD;
        SC_ENT:  k = 4'hE;
        default: k = 4'hF;
      endcase
    end else begin
      case (code)
        SC_0:     k = 4'h0;
        SC_1:     k = 4'h1;
        SC_2:     k = 4'h2;
        SC_3:     k = 4'h3;
        SC_4:     k = 4'h4;
        SC_5:     k = 4'h5;
        SC_6:     k = 4'h6;
        SC_7:     k = 4'h7;
        SC_8:     k = 4'h8;
        SC_9:     k = 4'h9;
        SC_PLUS:  k = 4'hA;
        SC_MINUS: k = 4'hB;
        SC_MUL:   k = 4'hC;
        SC_ENT:   k = 4'hE;
        SC_BS:    k = 4'hF;
        default:  k = 4'hF;
      endcase
    end
    return k;
  endfunction

  // Key F is both a real key (backspace) and the unmapped marker, so validity needs the code.
  function automatic logic key_ok(input logic [7:0] code, input logic ext, input logic [3:0] key);
    return (key != 4'hF) || (!ext && code == SC_BS);
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// rtl/ps2_evt_fifo.sv - first-word fall-through event FIFO with a registered head entry.
module ps2_evt_fifo #(
  parameter int               WIDTH    = 14,
  parameter int               DEPTH    = 8,
  parameter logic [WIDTH-1:0] HEAD_RST = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] head,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_n;
  logic [AW:0]      count;
  logic [AW:0]      count_n;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && valid;
  assign do_push  = push && (!full || do_pop);
  assign drop     = push && full && !do_pop;
  assign rd_ptr_n = do_pop ? rd_ptr + 1'b1 : rd_ptr;

  always_comb begin
    count_n = count;
    case ({do_push, do_pop})
      2'b10:   count_n = count + 1'b1;
      2'b01:   count_n = count - 1'b1;
      default: count_n = count;
    endcase
  end

  // The head register is reloaded from the entry that will be at the read pointer,
  // bypassing the array when that entry is being written in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      head   <= HEAD_RST;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_ptr_n;
      count  <= count_n;
      valid  <= (count_n != '0);
      if (count_n != '0) head <= (do_push && wr_ptr == rd_ptr_n) ? wdata : mem[rd_ptr_n];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - oversampled PS/2 receiver, prefix merge and event FIFO.
// Optional auto-repeat suppression when PS2_TYPEMATIC_FILTER_EN is defined.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic       iCLK_50,
  input  logic       iRST_n,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic       o_evt_valid,
  input  logic       i_evt_ready,
  output logic [7:0] o_evt_code,
  output logic       o_evt_ext,
  output logic       o_evt_brk,
  output logic [3:0] o_evt_key,
  output logic       o_evt_key_ok,
  output logic       o_frame_err,
  output logic       o_overflow,
  input  logic       i_ovf_clr
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int WW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic [FW-1:0] filt_cnt;
  logic          filt_clk;
  logic          filt_clk_d;
  logic          fall;
  logic          dat;

  always_ff @(posedge iCLK_50 or negedge iRST_n) begin
    if (!iRST_n) begin
      clk_sync   <= 2'b11;
      dat_sync   <= 2'b11;
      filt_cnt   <= '0;
      filt_clk   <= 1'b1;
      filt_clk_d <= 1'b1;
    end else begin
      clk_sync   <= {clk_sync[0], PS2_CLK};
      dat_sync   <= {dat_sync[0], PS2_DAT};
      filt_clk_d <= filt_clk;
      if (clk_sync[1] == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_clk <= clk_sync[1];
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall = filt_clk_d & ~filt_clk;
  assign dat  = dat_sync[1];

  rx_state_t     state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          par_ok, par_ok_n;
  logic [WW-1:0] wdog, wdog_n;
  logic          done_n, err_n;
  logic          byte_done;

  always_ff @(posedge iCLK_50 or negedge iRST_n) begin
    if (!iRST_n) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      par_ok      <= 1'b0;
      wdog        <= '0;
      byte_done   <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      shreg       <= shreg_n;
      par_ok      <= par_ok_n;
      wdog        <= wdog_n;
      byte_done   <= done_n;
      o_frame_err <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    par_ok_n  = par_ok;
    done_n    = 1'b0;
    err_n     = 1'b0;
    wdog_n    = (state == ST_IDLE || fall) ? '0 : wdog + 1'b1;
    if (fall) begin
      unique case (state)
        ST_IDLE: begin
          if (!dat) begin
            state_n   = ST_DATA;
            bit_cnt_n = '0;
          end
        end
        ST_DATA: begin
          shreg_n = {dat, shreg[7:1]};
          if (bit_cnt == 3'd7) state_n = ST_PARITY;
          else bit_cnt_n = bit_cnt + 1'b1;
        end
        ST_PARITY: begin
          par_ok_n = ^{shreg, dat};
          state_n  = ST_STOP;
        end
        ST_STOP: begin
          if (dat && par_ok) done_n = 1'b1;
          else err_n = 1'b1;
          state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end else if (state != ST_IDLE && wdog == WW'(TIMEOUT_CYC - 1)) begin
      err_n   = 1'b1;
      state_n = ST_IDLE;
    end
  end

  logic ext_pend;
  logic brk_pend;
  logic is_prefix;
  logic push;
  logic suppress;
  logic drop;
  evt_t new_evt;
  evt_t head_evt;
  logic [EVT_W-1:0] head_bits;

  assign is_prefix = (shreg == SC_EXT) || (shreg == SC_BRK);
  assign new_evt   = '{code: shreg, ext: ext_pend, brk: brk_pend, key: key_map(shreg, ext_pend)};
  assign push      = byte_done && !is_prefix && !suppress;

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [8:0] held_key;
  logic       held;
  logic       held_match;

  assign held_match = held && (held_key == {ext_pend, shreg});
  assign suppress   = !brk_pend && held_match;

  always_ff @(posedge iCLK_50 or negedge iRST_n) begin
    if (!iRST_n) begin
      held_key <= '0;
      held     <= 1'b0;
    end else if (byte_done && !is_prefix) begin
      if (brk_pend) begin
        if (held_match) held <= 1'b0;
      end else begin
        held_key <= {ext_pend, shreg};
        held     <= 1'b1;
      end
    end
  end
`else
  assign suppress = 1'b0;
`endif

  always_ff @(posedge iCLK_50 or negedge iRST_n) begin
    if (!iRST_n) begin
      ext_pend   <= 1'b0;
      brk_pend   <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      if (o_frame_err) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end else if (byte_done) begin
        if (shreg == SC_EXT) begin
          ext_pend <= 1'b1;
        end else if (shreg == SC_BRK) begin
          brk_pend <= 1'b1;
        end else begin
          ext_pend <= 1'b0;
          brk_pend <= 1'b0;
        end
      end
      // A drop in the same cycle as a clear request keeps the flag set.
      if (drop) o_overflow <= 1'b1;
      else if (i_ovf_clr) o_overflow <= 1'b0;
    end
  end

  ps2_evt_fifo #(
    .WIDTH   (EVT_W),
    .DEPTH   (FIFO_DEPTH),
    .HEAD_RST({8'h00, 1'b0, 1'b0, 4'hF})
  ) u_fifo (
    .clk  (iCLK_50),
    .rst_n(iRST_n),
    .push (push),
    .wdata(new_evt),
    .pop  (i_evt_ready),
    .valid(o_evt_valid),
    .head (head_bits),
    .drop (drop)
  );

  assign head_evt     = evt_t'(head_bits);
  assign o_evt_code   = head_evt.code;
  assign o_evt_ext    = head_evt.ext;
  assign o_evt_brk    = head_evt.brk;
  assign o_evt_key    = head_evt.key;
  assign o_evt_key_ok = key_ok(head_evt.code, head_evt.ext, head_evt.key);

endmodule
